alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
//   Registered execute stage directly downstream of the ALU control decoder.
//   Consumes the 3-bit ALUControl code plus two operands and produces result and zero flag.
//   Valid/ready handshake on both sides; a 2-entry output buffer (main + skid) gives full throughput.
//   Also keeps a wrapping count of completed operations for debug and performance use.
// PARAMETERS
//   WIDTH    32  operand/result width in bits (>=2)
//   CNT_W    32  width of the completed-operation counter
// PORTS
//   clk          in   1        single clock; all state updates on rising edge
//   rst          in   1        synchronous reset, active-high
//   in_valid     in   1        operands and ALUControl valid this cycle
//   in_ready     out  1        stage can accept; transfer when in_valid&&in_ready
//   alu_ctrl     in   3        ALUControl code from the ALU control decoder
//   src_a        in   WIDTH    operand A (rs1)
//   src_b        in   WIDTH    operand B (rs2 or immediate)
//   out_valid    out  1        result/zero/illegal valid
//   out_ready    in   1        consumer accepts; transfer when out_valid&&out_ready
//   result       out  WIDTH    ALU result
//   zero         out  1        1 when result==0 (branch compare)
//   illegal      out  1        alu_ctrl was not a defined code
//   op_count     out  CNT_W    number of input transfers accepted since reset
// BEHAVIOUR
//   Reset (rst=1 at edge): out_valid=0, result=0, zero=0, illegal=0, op_count=0, skid empty;
//     in_ready=1 in the cycle after reset. An in-flight op is discarded, never emitted.
//   Op codes (combinational in the accept cycle, registered into the buffer):
//     010 ADD  a+b mod 2^WIDTH     110 SUB  a-b mod 2^WIDTH (two's complement)
//     000 AND  a&b                 001 OR   a|b
//     111 SLT  signed(a)<signed(b) ? 1 : 0, zero-extended to WIDTH
//     011,100,101: result=0, zero=1, illegal=1 (the op still flows and is counted)
//   zero = ~|result, computed from the final result of the same op.
//   Latency: 1 cycle. An op accepted at edge N appears on the outputs after edge N
//     when the main register is empty or drains at N.
//   Buffering: main output register (drives outputs) + one skid register.
//     in_ready = ~skid_full (registered; never depends combinationally on out_ready).
//     Accept while main holds unconsumed data (out_valid&&!out_ready) -> op goes to skid.
//     Main drains (out_ready=1) with skid full -> skid moves to main; skid empties.
//     Main drains and input accepted in the same cycle with skid empty -> new op loads main directly.
//     Main drains and input accepted with skid full is impossible (in_ready=0).
//   Ordering: strictly FIFO; no op is dropped or duplicated.
//   Output stability: while out_valid=1 and out_ready=0, result/zero/illegal hold constant.
//   op_count increments by 1 on each input transfer and wraps 2^CNT_W-1 -> 0 without a flag.
//   in_valid=0: inputs ignored, no state change except draining.
// TESTING
//   1. ADD: ctrl=010 a=0x0000_0005 b=0x0000_0007, out_ready=1 -> next cycle result=0x0C, zero=0.
//   2. SUB/zero: ctrl=110 a=b=0x1234_5678 -> result=0, zero=1; ADD 0xFFFF_FFFF+1 -> result=0, zero=1 (wrap).
//   3. SLT: ctrl=111 a=0xFFFF_FFFF b=0x1 -> result=1; swap operands -> result=0.
//   4. Backpressure: out_ready=0, send 3 ops back-to-back -> in_ready drops after 2nd accept;
//      raise out_ready -> ops emerge in order, one per cycle, none lost; op_count=3.
//   5. Illegal: ctrl=100 a=0xFF b=0x1 -> result=0, zero=1, illegal=1; op_count increments.
//   6. Reset mid-op: both buffers full, assert rst one cycle -> out_valid=0, op_count=0,
//      in_ready=1 next cycle; the next accepted op emerges first.

Source files
------------

// File: rtl/alu_exec_stage_if.sv
// Handshake and data bundle for the ALU execute stage.
// Upstream side: in_valid/in_ready, alu_ctrl, src_a, src_b.
// Downstream side: out_valid/out_ready, result, zero, illegal.
// Debug side: op_count.
// master: the environment around the stage (producer plus consumer).
// slave:  the stage itself.
interface alu_exec_stage_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       alu_ctrl;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             illegal;
   logic [CNT_W-1:0] op_count;

   modport master (
      output in_valid, alu_ctrl, src_a, src_b, out_ready,
      input  in_ready, out_valid, result, zero, illegal, op_count
   );

   modport slave (
      input  in_valid, alu_ctrl, src_a, src_b, out_ready,
      output in_ready, out_valid, result, zero, illegal, op_count
   );
endinterface

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with a main output register plus one skid
// register, so that a full-rate stream passes even though in_ready is a
// pure register output.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous reset, active-high
//   bus  - alu_exec_stage_if.slave: operand handshake in, result handshake
//          out, and the count of accepted operations
//
// Buffer occupancy (implied by out_valid / skid_full):
//   state       | meaning
//   empty       | out_valid=0, skid_full=0, nothing held
//   main        | out_valid=1, skid_full=0, one op presented
//   main+skid   | out_valid=1, skid_full=1, in_ready=0
module alu_exec_stage #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 32
) (
   input logic             clk,
   input logic             rst,
   alu_exec_stage_if.slave bus
);
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   logic [WIDTH-1:0] main_result, skid_result, alu_result;
   logic             main_zero, skid_zero, alu_zero;
   logic             main_illegal, skid_illegal, alu_illegal;
   logic             main_valid, skid_full;
   logic [CNT_W-1:0] op_count;
   logic             accept, main_free;

   always_comb begin
      alu_result  = '0;
      alu_illegal = 1'b0;
      unique case (bus.alu_ctrl)
         OP_AND:  alu_result = bus.src_a & bus.src_b;
         OP_OR:   alu_result = bus.src_a | bus.src_b;
         OP_ADD:  alu_result = bus.src_a + bus.src_b;
         OP_SUB:  alu_result = bus.src_a - bus.src_b;
         OP_SLT:  alu_result = {{(WIDTH-1){1'b0}},
                                ($signed(bus.src_a) < $signed(bus.src_b))};
         default: alu_illegal = 1'b1;
      endcase
      alu_zero = ~|alu_result;
   end

   assign accept    = bus.in_valid && !skid_full;
   // Main register can take new data if it is empty or being consumed now.
   assign main_free = !main_valid || bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid   <= 1'b0;
         main_result  <= '0;
         main_zero    <= 1'b0;
         main_illegal <= 1'b0;
         skid_full    <= 1'b0;
         skid_result  <= '0;
         skid_zero    <= 1'b0;
         skid_illegal <= 1'b0;
         op_count     <= '0;
      end else begin
         if (accept) op_count <= op_count + CNT_W'(1);

         if (main_free) begin
            // Skid is only ever full while main is full, and accept is
            // blocked while skid is full, so these branches are exclusive.
            if (skid_full) begin
               main_valid   <= 1'b1;
               main_result  <= skid_result;
               main_zero    <= skid_zero;
               main_illegal <= skid_illegal;
               skid_full    <= 1'b0;
            end else if (accept) begin
               main_valid   <= 1'b1;
               main_result  <= alu_result;
               main_zero    <= alu_zero;
               main_illegal <= alu_illegal;
            end else begin
               main_valid   <= 1'b0;
            end
         end else if (accept) begin
            skid_full    <= 1'b1;
            skid_result  <= alu_result;
            skid_zero    <= alu_zero;
            skid_illegal <= alu_illegal;
         end
      end
   end

   assign bus.in_ready  = !skid_full;
   assign bus.out_valid = main_valid;
   assign bus.result    = main_result;
   assign bus.zero      = main_zero;
   assign bus.illegal   = main_illegal;
   assign bus.op_count  = op_count;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: opcode vectors, wrap/zero cases,
// backpressure through the skid register, illegal codes and mid-flight reset.
module tb_alu_exec_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_bad = 0;
   int   cnt_exp = 0;

   always #5 clk = ~clk;

   alu_exec_stage_if #(.WIDTH(32), .CNT_W(32)) bus ();

   alu_exec_stage #(.WIDTH(32), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cnt_exp = 0;
   endtask

   // Present one op for one cycle, then sample at the following negedge.
   task automatic send(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      bus.in_valid = 1'b1;
      bus.alu_ctrl = c;
      bus.src_a    = a;
      bus.src_b    = b;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic run_vec(input string tag, input logic [2:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic ez,
                          input logic ei);
      send(c, a, b);
      cnt_exp++;
      chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, "_result"}, 64'(bus.result), 64'(er));
      chk({tag, "_zero"}, 64'(bus.zero), 64'(ez));
      chk({tag, "_illegal"}, 64'(bus.illegal), 64'(ei));
      chk({tag, "_count"}, 64'(bus.op_count), 64'(cnt_exp));
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.alu_ctrl  = 3'b000;
      bus.src_a     = '0;
      bus.src_b     = '0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      do_reset();

      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_result", 64'(bus.result), 64'd0);
      chk("rst_zero", 64'(bus.zero), 64'd0);
      chk("rst_illegal", 64'(bus.illegal), 64'd0);
      chk("rst_count", 64'(bus.op_count), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

      run_vec("add",      3'b010, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0, 1'b0);
      run_vec("sub_eq",   3'b110, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0);
      run_vec("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
      run_vec("sub_neg",  3'b110, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run_vec("and",      3'b000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 1'b0);
      run_vec("or",       3'b001, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 1'b0, 1'b0);
      run_vec("slt_neg",  3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
      run_vec("slt_swap", 3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
      run_vec("ill_100",  3'b100, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1);
      run_vec("ill_011",  3'b011, 32'h0000_0004, 32'h0000_0004, 32'h0000_0000, 1'b1, 1'b1);
      run_vec("ill_101",  3'b101, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b1);

      // Idle cycle with out_ready=1 drains the last op.
      @(posedge clk);
      @(negedge clk);
      chk("idle_drain", 64'(bus.out_valid), 64'd0);
      chk("idle_count", 64'(bus.op_count), 64'(cnt_exp));

      // Backpressure: three back-to-back ops against a stalled consumer.
      do_reset();
      bus.out_ready = 1'b0;
      send(3'b010, 32'd1, 32'd1);
      chk("bp_ready_1", 64'(bus.in_ready), 64'd1);
      chk("bp_first", 64'(bus.result), 64'd2);
      send(3'b010, 32'd2, 32'd2);
      chk("bp_ready_2", 64'(bus.in_ready), 64'd0);
      chk("bp_hold_a", 64'(bus.result), 64'd2);
      bus.in_valid = 1'b1;
      bus.alu_ctrl = 3'b010;
      bus.src_a    = 32'd3;
      bus.src_b    = 32'd3;
      @(posedge clk);
      @(negedge clk);
      chk("bp_blocked_cnt", 64'(bus.op_count), 64'd2);
      chk("bp_hold_b", 64'(bus.result), 64'd2);
      chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_second", 64'(bus.result), 64'd4);
      chk("bp_ready_back", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("bp_third", 64'(bus.result), 64'd6);
      chk("bp_third_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_count", 64'(bus.op_count), 64'd3);
      @(posedge clk);
      @(negedge clk);
      chk("bp_empty", 64'(bus.out_valid), 64'd0);

      // Reset with both registers occupied.
      bus.out_ready = 1'b0;
      send(3'b010, 32'd10, 32'd10);
      send(3'b010, 32'd20, 32'd20);
      chk("rm_full", 64'(bus.in_ready), 64'd0);
      do_reset();
      chk("rm_valid", 64'(bus.out_valid), 64'd0);
      chk("rm_count", 64'(bus.op_count), 64'd0);
      chk("rm_ready", 64'(bus.in_ready), 64'd1);
      bus.out_ready = 1'b1;
      run_vec("rm_next", 3'b010, 32'd9, 32'd1, 32'd10, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("rm_no_stale", 64'(bus.out_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
